// File: rtl/mem_multi_access.sv
// LM/SM memory-stage sequencer: one data-memory access per set mask bit at consecutive addresses.
// Optional store-data forwarding from write-back is enabled by defining MEM_ACCESS_FWD_EN.
module mem_multi_access #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int NREG   = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_store,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [NREG-1:0]   in_mask,
  output logic [IDX_W-1:0]  rf_rd_idx,
  input  logic [DATA_W-1:0] rf_rd_data,
  input  logic              fwd_valid,
  input  logic [IDX_W-1:0]  fwd_idx,
  input  logic [DATA_W-1:0] fwd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [IDX_W-1:0]  wb_idx,
  output logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    EMPTY = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [NREG-1:0]   mask_r;
  logic [NREG-1:0]   mask_clr_s;
  logic [ADDR_W-1:0] addr_r;
  logic              is_store_r;
  logic [IDX_W-1:0]  cur_idx_s;
  logic              wb_valid_r;
  logic [IDX_W-1:0]  wb_idx_r;
  logic [DATA_W-1:0] wb_data_r;
  logic              run_s;
  logic              accept_s;

  // Priority encoder: lowest set bit wins, zero mask yields index 0.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NREG-1:0] m);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = NREG - 1; i >= 0; i--) begin
      if (m[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign run_s      = (state_r == RUN);
  assign accept_s   = (state_r == IDLE) && in_valid;
  assign cur_idx_s  = lowest_set(mask_r);
  assign mask_clr_s = mask_r & ~({{(NREG-1){1'b0}}, 1'b1} << cur_idx_s);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request capture, then per-access mask clear and address advance.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_r     <= {NREG{1'b0}};
      addr_r     <= {ADDR_W{1'b0}};
      is_store_r <= 1'b0;
    end else if (accept_s) begin
      mask_r     <= in_mask;
      addr_r     <= in_base;
      is_store_r <= in_is_store;
    end else if (run_s) begin
      mask_r     <= mask_clr_s;
      addr_r     <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      is_store_r <= is_store_r;
    end else begin
      mask_r     <= mask_r;
      addr_r     <= addr_r;
      is_store_r <= is_store_r;
    end
  end

  // Load write-back register; a reset edge drops any pending result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wb_valid_r <= 1'b0;
      wb_idx_r   <= {IDX_W{1'b0}};
      wb_data_r  <= {DATA_W{1'b0}};
    end else if (run_s && !is_store_r) begin
      wb_valid_r <= 1'b1;
      wb_idx_r   <= cur_idx_s;
      wb_data_r  <= mem_rdata;
    end else begin
      wb_valid_r <= 1'b0;
      wb_idx_r   <= wb_idx_r;
      wb_data_r  <= wb_data_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = (in_mask == {NREG{1'b0}}) ? EMPTY : RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (mask_clr_s == {NREG{1'b0}}) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      EMPTY:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Outputs decoded from state; store data is the only path from live inputs.
  always_comb begin
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    done      = 1'b0;
    mem_addr  = addr_r;
    rf_rd_idx = cur_idx_s;
    case (state_r)
      IDLE: in_ready = 1'b1;
      RUN: begin
        mem_we = is_store_r;
        done   = (mask_clr_s == {NREG{1'b0}});
      end
      EMPTY:   done = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

`ifdef MEM_ACCESS_FWD_EN
  // Forward a same-cycle write-back to the register being stored.
  always_comb begin
    if (fwd_valid && (fwd_idx == cur_idx_s)) begin
      mem_wdata = fwd_data;
    end else begin
      mem_wdata = rf_rd_data;
    end
  end
`else
  logic unused_fwd_s;
  assign unused_fwd_s = ^{fwd_valid, fwd_idx, fwd_data};
  assign mem_wdata    = rf_rd_data;
`endif

  assign stall    = !in_ready;
  assign wb_valid = wb_valid_r;
  assign wb_idx   = wb_idx_r;
  assign wb_data  = wb_data_r;

endmodule

// File: tb/tb_mem_multi_access.sv
// Directed table-driven bench for mem_multi_access; build with or without MEM_ACCESS_FWD_EN.
module tb_mem_multi_access;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_store;
  logic [15:0] in_base;
  logic [7:0]  in_mask;
  logic [2:0]  rf_rd_idx;
  logic [15:0] rf_rd_data;
  logic        fwd_valid;
  logic [2:0]  fwd_idx;
  logic [15:0] fwd_data;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic        wb_valid;
  logic [2:0]  wb_idx;
  logic [15:0] wb_data;
  logic        stall;
  logic        done;

  logic [15:0] rf [8];
  int n_cmp = 0;
  int n_err = 0;

`ifdef MEM_ACCESS_FWD_EN
  localparam logic [15:0] EXP_FWD = 16'h2222;
`else
  localparam logic [15:0] EXP_FWD = 16'h1111;
`endif

  typedef struct {
    logic        rst;
    logic        vld;
    logic        st;
    logic [15:0] base;
    logic [7:0]  mask;
    logic        fv;
    logic [2:0]  fi;
    logic [15:0] fd;
    logic        e_rdy;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_wd;
    logic        e_done;
    logic        e_wbv;
    logic [2:0]  e_wbi;
    logic [15:0] e_wbd;
  } vec_t;

  vec_t vecs[$];

  mem_multi_access dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_is_store(in_is_store),
    .in_base    (in_base),
    .in_mask    (in_mask),
    .rf_rd_idx  (rf_rd_idx),
    .rf_rd_data (rf_rd_data),
    .fwd_valid  (fwd_valid),
    .fwd_idx    (fwd_idx),
    .fwd_data   (fwd_data),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_idx     (wb_idx),
    .wb_data    (wb_data),
    .stall      (stall),
    .done       (done)
  );

  always #5 clk = ~clk;

  assign rf_rd_data = rf[rf_rd_idx];
  assign mem_rdata  = (mem_addr == 16'h0100) ? 16'h1234 :
                      (mem_addr == 16'h0101) ? 16'h5678 : 16'h0000;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one vector, clock it, then check the cycle after the edge with inputs still applied.
  task automatic apply(input vec_t v, input int id);
    reset_n     = v.rst;
    in_valid    = v.vld;
    in_is_store = v.st;
    in_base     = v.base;
    in_mask     = v.mask;
    fwd_valid   = v.fv;
    fwd_idx     = v.fi;
    fwd_data    = v.fd;
    @(posedge clk);
    #1;
    check($sformatf("v%0d.in_ready", id), {15'd0, in_ready}, {15'd0, v.e_rdy});
    check($sformatf("v%0d.stall", id),    {15'd0, stall},    {15'd0, !v.e_rdy});
    check($sformatf("v%0d.mem_we", id),   {15'd0, mem_we},   {15'd0, v.e_we});
    check($sformatf("v%0d.done", id),     {15'd0, done},     {15'd0, v.e_done});
    check($sformatf("v%0d.wb_valid", id), {15'd0, wb_valid}, {15'd0, v.e_wbv});
    if (v.e_we) begin
      check($sformatf("v%0d.mem_addr", id),  mem_addr,  v.e_addr);
      check($sformatf("v%0d.mem_wdata", id), mem_wdata, v.e_wd);
    end
    if (v.e_wbv) begin
      check($sformatf("v%0d.wb_idx", id),  {13'd0, wb_idx}, {13'd0, v.e_wbi});
      check($sformatf("v%0d.wb_data", id), wb_data, v.e_wbd);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    rf[0] = 16'h00A0; rf[1] = 16'h00B1; rf[2] = 16'h00A2;
    rf[5] = 16'h00A5; rf[7] = 16'h00A7;

    // Idle after reset
    vecs.push_back('{1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,3'd0,16'h0000, 1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b0,3'd0,16'h0000});
    // SM base 0x10 mask A5; busy-time in_valid with a zero mask must be ignored
    vecs.push_back('{1'b1,1'b1,1'b1,16'h0010,8'hA5,1'b0,3'd0,16'h0000, 1'b0,1'b1,16'h0010,16'h00A0,1'b0,1'b0,3'd0,16'h0000});
    vecs.push_back('{1'b1,1'b1,1'b0,16'h0000,8'h00,1'b0,3'd0,16'h0000, 1'b0,1'b1,16'h0011,16'h00A2,1'b0,1'b0,3'd0,16'h0000});
    vecs.push_back('{1'b1,1'b1,1'b0,16'h0000,8'h00,1'b0,3'd0,16'h0000, 1'b0,1'b1,16'h0012,16'h00A5,1'b0,1'b0,3'd0,16'h0000});
    vecs.push_back('{1'b1,1'b1,1'b0,16'h0000,8'h00,1'b0,3'd0,16'h0000, 1'b0,1'b1,16'h0013,16'h00A7,1'b1,1'b0,3'd0,16'h0000});
    vecs.push_back('{1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,3'd0,16'h0000, 1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b0,3'd0,16'h0000});
    // LM base 0x100 mask 03
    vecs.push_back('{1'b1,1'b1,1'b0,16'h0100,8'h03,1'b0,3'd0,16'h0000, 1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,3'd0,16'h0000});
    vecs.push_back('{1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,3'd0,16'h0000, 1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b1,3'd0,16'h1234});
    vecs.push_back('{1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,3'd0,16'h0000, 1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b1,3'd1,16'h5678});
    // Zero mask accepted in the same cycle as the last load write-back
    vecs.push_back('{1'b1,1'b1,1'b0,16'h0300,8'h00,1'b0,3'd0,16'h0000, 1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b0,3'd0,16'h0000});
    vecs.push_back('{1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,3'd0,16'h0000, 1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b0,3'd0,16'h0000});
    // Address wrap
    vecs.push_back('{1'b1,1'b1,1'b1,16'hFFFF,8'h03,1'b0,3'd0,16'h0000, 1'b0,1'b1,16'hFFFF,16'h00A0,1'b0,1'b0,3'd0,16'h0000});
    vecs.push_back('{1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,3'd0,16'h0000, 1'b0,1'b1,16'h0000,16'h00B1,1'b1,1'b0,3'd0,16'h0000});
    vecs.push_back('{1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,3'd0,16'h0000, 1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b0,3'd0,16'h0000});

    // Reset state
    reset_n = 1'b0; in_valid = 1'b0; in_is_store = 1'b0; in_base = 16'h0000;
    in_mask = 8'h00; fwd_valid = 1'b0; fwd_idx = 3'd0; fwd_data = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready",  {15'd0, in_ready}, 16'h0001);
    check("rst.stall",     {15'd0, stall},    16'h0000);
    check("rst.mem_we",    {15'd0, mem_we},   16'h0000);
    check("rst.done",      {15'd0, done},     16'h0000);
    check("rst.wb_valid",  {15'd0, wb_valid}, 16'h0000);
    check("rst.wb_idx",    {13'd0, wb_idx},   16'h0000);
    check("rst.wb_data",   wb_data,           16'h0000);
    check("rst.mem_addr",  mem_addr,          16'h0000);
    check("rst.rf_rd_idx", {13'd0, rf_rd_idx}, 16'h0000);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Forwarding on the matching index, then a non-matching index
    rf[2] = 16'h1111;
    apply('{1'b1,1'b1,1'b1,16'h0200,8'h04,1'b1,3'd2,16'h2222, 1'b0,1'b1,16'h0200,EXP_FWD,1'b1,1'b0,3'd0,16'h0000}, 100);
    apply('{1'b1,1'b0,1'b0,16'h0000,8'h00,1'b1,3'd2,16'h2222, 1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b0,3'd0,16'h0000}, 101);
    apply('{1'b1,1'b1,1'b1,16'h0200,8'h04,1'b1,3'd3,16'h2222, 1'b0,1'b1,16'h0200,16'h1111,1'b1,1'b0,3'd0,16'h0000}, 102);
    apply('{1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,3'd0,16'h0000, 1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b0,3'd0,16'h0000}, 103);

    // Reset in the middle of SM mask FF stops writes at once
    apply('{1'b1,1'b1,1'b1,16'h0000,8'hFF,1'b0,3'd0,16'h0000, 1'b0,1'b1,16'h0000,16'h00A0,1'b0,1'b0,3'd0,16'h0000}, 200);
    apply('{1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,3'd0,16'h0000, 1'b0,1'b1,16'h0001,16'h00B1,1'b0,1'b0,3'd0,16'h0000}, 201);
    apply('{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b0,3'd0,16'h0000, 1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b0,3'd0,16'h0000}, 202);
    apply('{1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,3'd0,16'h0000, 1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b0,3'd0,16'h0000}, 203);
    apply('{1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,3'd0,16'h0000, 1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b0,3'd0,16'h0000}, 204);

    // Reset right after a load access drops its pending write-back
    apply('{1'b1,1'b1,1'b0,16'h0100,8'h03,1'b0,3'd0,16'h0000, 1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,3'd0,16'h0000}, 300);
    apply('{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b0,3'd0,16'h0000, 1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b0,3'd0,16'h0000}, 301);
    apply('{1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,3'd0,16'h0000, 1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b0,3'd0,16'h0000}, 302);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_multi_access.md
# mem_multi_access

Memory-stage sequencer for multi-register load/store (LM/SM). It walks an NREG-bit register mask, one data-memory access per set bit per cycle, at consecutive addresses from a base. Store data can be forwarded from the write-back stage. It stalls the upstream pipeline while busy and returns load results on a registered write-back port. It sits between the EX/MEM pipeline register, the register file read port, the data memory and the MEM/WB write-back path.

## Interface
- DATA_W, 16, data word width
- ADDR_W, 16, memory address width
- NREG, 8, register-mask width (number of architectural registers)
- IDX_W, 3, register index width; NREG ≤ 2^IDX_W

- clk  in  1  clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  request from EX/MEM
- in_ready  out  1  sequencer can accept a request
- in_is_store  in  1  1 = SM, 0 = LM
- in_base  in  ADDR_W  first transfer address
- in_mask  in  NREG  bit i set = transfer register i
- rf_rd_idx  out  IDX_W  register-file read index (store data)
- rf_rd_data  in  DATA_W  combinational register-file read data
- fwd_valid  in  1  write-back stage is writing a register this cycle
- fwd_idx  in  IDX_W  write-back destination index
- fwd_data  in  DATA_W  write-back data
- mem_addr  out  ADDR_W  data-memory address
- mem_wdata  out  DATA_W  data-memory write data
- mem_we  out  1  data-memory write enable
- mem_rdata  in  DATA_W  combinational data-memory read data
- wb_valid  out  1  load result valid
- wb_idx  out  IDX_W  load destination register
- wb_data  out  DATA_W  load data
- stall  out  1  hold upstream stages; equals !in_ready
- done  out  1  one-cycle pulse, request complete

## Operation
- States: IDLE, RUN, EMPTY. in_ready = (state == IDLE).
- IDLE: on in_valid, latch is_store, the address (= in_base) and the remaining mask (= in_mask).
  - Nonzero mask: go to RUN.
  - Zero mask: go to EMPTY.
  - in_valid while busy is ignored. Upstream must hold the request while stall is high.
- RUN: the current index is the lowest set bit of the remaining mask (priority encoder, bit 0 first).
  - rf_rd_idx and mem_addr = current index and current address.
  - mem_we = is_store.
  - Each cycle: clear the current bit and increment the address by 1, modulo 2^ADDR_W (wrap 0xFFFF → 0x0000 at default width).
  - When the cleared mask becomes zero: assert done this cycle and go to IDLE.
- EMPTY: assert done for one cycle, no memory access, go to IDLE.
- Load (is_store = 0): each RUN cycle registers mem_rdata and the current index into wb_data/wb_idx, with wb_valid = 1 in the following cycle. wb_valid is 0 otherwise.
- Store data (MEM_ACCESS_FWD_EN defined):
  - mem_wdata = fwd_data if fwd_valid && fwd_idx == current index.
  - Otherwise mem_wdata = rf_rd_data.
- mem_we is 0 in IDLE and EMPTY and for loads. mem_addr, rf_rd_idx and mem_wdata are don't-care when mem_we = 0 and the state is not RUN.
- Reset (reset_n = 0 at an edge, including mid-RUN): state → IDLE, mask cleared, address 0, wb_valid 0, done 0. No further memory writes after that edge. Pending load write-backs are dropped.
- Reset values: in_ready 1, stall 0, mem_we 0, done 0, wb_valid 0, wb_idx 0, wb_data 0, mem_addr 0, rf_rd_idx 0.

## Timing
- Request accepted at edge k with popcount(mask) = n ≥ 1:
  - Accesses occur in cycles k+1 … k+n.
  - done is high in cycle k+n.
  - in_ready is high again in cycle k+n+1.
- Zero mask: done in cycle k+1, in_ready in cycle k+2.
- Load write-back lags its access by exactly 1 cycle. The last wb_valid (cycle k+n+1) may coincide with a new request being accepted.
- Back-to-back requests: throughput is n+1 cycles per request.
- Forwarding mux and priority encoder are combinational within the access cycle. No extra latency.

## Configuration
- MEM_ACCESS_FWD_EN defined: store-data forwarding from fwd_* as above.
- MEM_ACCESS_FWD_EN undefined: fwd_valid/fwd_idx/fwd_data are present but ignored, and mem_wdata = rf_rd_data always. All other behaviour and timing are identical.

## Test plan
- Reset, then idle: in_ready 1, mem_we 0, wb_valid 0. Drive reset_n 0 mid-RUN of SM mask 0xFF → no mem_we from the next cycle, in_ready 1.
- SM base 0x0010, mask 0b1010_0101, R0/R2/R5/R7 = 0xA0/0xA2/0xA5/0xA7:
  - Writes 0xA0@0x10, 0xA2@0x11, 0xA5@0x12, 0xA7@0x13 in cycles k+1..k+4.
  - done in k+4, in_ready in k+5.
- LM base 0x0100, mask 0x03, mem[0x100] = 0x1234, mem[0x101] = 0x5678:
  - wb (idx 0, 0x1234) in k+2.
  - wb (idx 1, 0x5678) in k+3.
  - mem_we stays 0.
- Zero mask: done in k+1, no mem_we, in_ready low for exactly one cycle.
- Wrap: SM base 0xFFFF, mask 0x03 → addresses 0xFFFF then 0x0000.
- Forwarding (MEM_ACCESS_FWD_EN defined): SM mask 0x04, rf R2 = 0x1111, fwd_valid 1, fwd_idx 2, fwd_data 0x2222 in the access cycle.
  - Written data is 0x2222.
  - With the macro undefined, written data is 0x1111.
  - With fwd_idx 3, written data is 0x1111.
